demux1to4_buf: RTL
==================

// Module: demux1to4_buf
// PURPOSE
//  Buffered 1-to-4 distributor: the steering counterpart of the datapath 4-to-1 selectors.
//  - Accepts one WIDTH-bit word per cycle on a valid/ready input port.
//  - Routes each word by a 2-bit sel into one of four per-lane FIFOs (DEPTH entries each).
//  - Each lane drains independently on its own valid/ready port.
//  - Sits between a single producer (e.g. ALU/memory result path) and four consumers.
// PARAMETERS
//  WIDTH  32  data width of every lane
//  DEPTH  2   entries per lane FIFO; power of two, >= 2
// PORTS
//  CLK        in   1         clock, all state updates on rising edge
//  Reset      in   1         asynchronous, active-high; clears all state
//  in_valid   in   1         producer presents a word
//  in_ready   out  1         distributor can accept the word this cycle
//  sel        in   2         destination lane 0..3; ignored when in_valid=0
//  DataIn     in   WIDTH     word to route
//  out_valid  out  4         lane i head word valid
//  out_ready  in   4         consumer i takes head word
//  DataOut    out  4*WIDTH   lane i head word at [i*WIDTH +: WIDTH]
//  busy       out  1         any lane non-empty
// BEHAVIOUR
//  - Reset (async assert, any cycle): all counts/pointers=0, buffered data discarded.
//    -> out_valid=4'b0, DataOut=0, busy=0, in_ready=1.
//    Release is synchronous to CLK; first accept possible on the first edge after deassert.
//  - Per lane i: cnt[i] is clog2(DEPTH+1) bits, wr_ptr/rd_ptr are clog2(DEPTH) bits.
//    Pointers wrap modulo DEPTH.
//  - in_ready = (cnt[sel] != DEPTH); combinational from sel and cnt only, never from in_valid.
//  - push = in_valid & in_ready: DataIn written at wr_ptr[sel]; wr_ptr[sel]++, cnt[sel]++.
//  - out_valid[i] = (cnt[i] != 0); DataOut lane i = mem[i][rd_ptr[i]], else lane i = 0.
//  - pop[i] = out_valid[i] & out_ready[i]: rd_ptr[i]++, cnt[i]--.
//  - Latency: word pushed at edge N -> out_valid[sel]=1 after edge N. No combinational bypass.
//  - Same-lane push+pop in one cycle: cnt unchanged, both pointers advance.
//    Legal only when the lane is not full.
//  - Full lane: in_ready=0 even if that lane pops the same cycle (no full-lane bypass).
//    Producer holds DataIn/sel stable until accepted.
//  - Blocking on a full lane stalls only the producer; other lanes keep draining.
//  - Words to the same lane are delivered in arrival order; no ordering guarantee across lanes.
//  - out_ready asserted on an empty lane has no effect. sel=X with in_valid=0 has no effect.
//  - busy = |out_valid (combinational).
// CONFIGURATION
//  DEMUX4_BCAST_EN defined:
//  - Adds input port bcast (1 bit).
//  - in_valid & bcast: word targets all four lanes; sel ignored.
//  - in_ready = no lane full; push writes all four lanes on the same edge.
//  DEMUX4_BCAST_EN undefined:
//  - No bcast port; unicast only as above.
// TESTING
//  - Reset: assert Reset mid-traffic with lanes holding data
//    -> out_valid=0, DataOut=0, busy=0, in_ready=1 immediately (async).
//  - Unicast: push 0xA5A5_0001 sel=2, out_ready=0
//    -> out_valid=4'b0100 next cycle, lane2=0xA5A5_0001.
//  - Fill + order: push 0x11 then 0x22 to lane1 (DEPTH=2), out_ready=0
//    -> in_ready=0 while sel=1, in_ready=1 while sel=0.
//    Then pop twice -> 0x11 then 0x22, out_valid[1]=0 after.
//  - Simultaneous: lane3 cnt=1, push 0x33 + pop same cycle
//    -> cnt stays 1, head becomes 0x33; wrap across 4 such cycles returns correct order.
//  - Full-lane stall: lane0 full, out_ready[0]=1, in_valid=1 sel=0
//    -> no accept that cycle; accepted next cycle after the pop.
//  - BCAST_EN: bcast=1 word 0xFFFF_0000 with lane2 full
//    -> in_ready=0; after lane2 pop, all four lanes show 0xFFFF_0000.

Source files
------------

// File: rtl/demux1to4_buf_if.sv
// -----------------------------------------------------------------------------
// demux1to4_buf_if
//   Bus bundle for the buffered 1-to-4 distributor.
//   Producer side : in_valid, in_ready, sel, DataIn (+ bcast when
//                   DEMUX4_BCAST_EN is defined)
//   Consumer side : out_valid[3:0], out_ready[3:0], DataOut[4*WIDTH-1:0]
//   Status        : busy
//   Modports: master = producer/consumer environment, slave = distributor.
// -----------------------------------------------------------------------------
interface demux1to4_buf_if #(
   parameter int WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           sel;
   logic [WIDTH-1:0]     DataIn;
   logic [3:0]           out_valid;
   logic [3:0]           out_ready;
   logic [4*WIDTH-1:0]   DataOut;
   logic                 busy;
`ifdef DEMUX4_BCAST_EN
   logic                 bcast;

   modport master (
      output in_valid, sel, DataIn, bcast, out_ready,
      input  in_ready, out_valid, DataOut, busy
   );
   modport slave (
      input  in_valid, sel, DataIn, bcast, out_ready,
      output in_ready, out_valid, DataOut, busy
   );
`else
   modport master (
      output in_valid, sel, DataIn, out_ready,
      input  in_ready, out_valid, DataOut, busy
   );
   modport slave (
      input  in_valid, sel, DataIn, out_ready,
      output in_ready, out_valid, DataOut, busy
   );
`endif
endinterface

// File: rtl/demux1to4_buf.sv
// -----------------------------------------------------------------------------
// demux1to4_buf
//   Buffered 1-to-4 distributor. One WIDTH-bit word per cycle is accepted on a
//   valid/ready input and steered by sel into one of four DEPTH-entry FIFOs;
//   each lane drains on its own valid/ready port.
//
//   Ports:
//     CLK    - clock, rising edge
//     Reset  - asynchronous, active-high; discards all buffered words
//     bus    - demux1to4_buf_if.slave (in_valid/in_ready/sel/DataIn,
//              out_valid/out_ready/DataOut, busy)
//
//   Optional feature: DEMUX4_BCAST_EN adds bus.bcast; a broadcast word is
//   written to all four lanes on one edge and is accepted only when no lane
//   is full.
//
//   Parameters: WIDTH (data width), DEPTH (entries per lane, power of two >= 2)
// -----------------------------------------------------------------------------
module demux1to4_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input logic             CLK,
   input logic             Reset,
   demux1to4_buf_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [3:0] laneFull;
   logic [3:0] push;
   logic [3:0] pop;
   logic       bcastSel;

`ifdef DEMUX4_BCAST_EN
   assign bcastSel     = bus.bcast;
   // Broadcast needs room in every lane; unicast only in the addressed one.
   assign bus.in_ready = bus.bcast ? ~|laneFull : ~laneFull[bus.sel];
`else
   assign bcastSel     = 1'b0;
   assign bus.in_ready = ~laneFull[bus.sel];
`endif

   assign bus.busy = |bus.out_valid;

   for (genvar g = 0; g < 4; g++) begin : gLane
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wrPtr;
      logic [PTR_W-1:0] rdPtr;
      logic [CNT_W-1:0] cnt;

      assign laneFull[g]      = (cnt == CNT_W'(DEPTH));
      assign bus.out_valid[g] = (cnt != '0);
      assign push[g]          = bus.in_valid & bus.in_ready &
                                (bcastSel | (bus.sel == 2'(g)));
      assign pop[g]           = bus.out_valid[g] & bus.out_ready[g];

      // Empty lanes present zero rather than stale storage.
      assign bus.DataOut[g*WIDTH +: WIDTH] = bus.out_valid[g] ? mem[rdPtr] : '0;

      // Pointers wrap naturally because DEPTH is a power of two.
      always_ff @(posedge CLK or posedge Reset) begin
         if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
         end else begin
            if (push[g]) wrPtr <= wrPtr + PTR_W'(1);
            if (pop[g])  rdPtr <= rdPtr + PTR_W'(1);
            case ({push[g], pop[g]})
               2'b10:   cnt <= cnt + CNT_W'(1);
               2'b01:   cnt <= cnt - CNT_W'(1);
               default: cnt <= cnt;
            endcase
         end
      end

      // Storage needs no reset: it is only visible while cnt is non-zero.
      always_ff @(posedge CLK) begin
         if (push[g]) mem[wrPtr] <= bus.DataIn;
      end
   end
endmodule
